// File: rtl/rv32i_types_pkg.sv
// Scalar RV32I types shared by the vector memory path: machine word and load kinds.
package rv32i_types_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_t;

endpackage

// File: rtl/rv32v_types_pkg.sv
// RV32V vector types: lane count, deserializer FSM states, request tag and load alignment helper.
package rv32v_types_pkg;

    import rv32i_types_pkg::*;

    localparam int unsigned NUM_LANES = 2;
    localparam int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } vdeser_state_t;

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        load_t             ltype;
        logic [1:0]        boff;
    } vdeser_tag_t;

    // Align the raw word by the byte offset, then sign/zero-extend for sub-word loads.
    function automatic word_t load_extend(load_t ltype, logic [1:0] boff, word_t raw);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = 8'(raw >> {boff, 3'b000});
        half_v = 16'(raw >> {boff, 3'b000});
        case (ltype)
            LB:      load_extend = {{24{byte_v[7]}}, byte_v};
            LBU:     load_extend = {24'd0, byte_v};
            LH:      load_extend = {{16{half_v[15]}}, half_v};
            LHU:     load_extend = {16'd0, half_v};
            default: load_extend = raw;
        endcase
    endfunction

endpackage

// File: rtl/rv32v_deser_tag_fifo.sv
// In-order tag FIFO for outstanding vector load requests; push and pop may coincide when full.
module rv32v_deser_tag_fifo
    import rv32v_types_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             push,
    input  vdeser_tag_t      push_tag,
    input  logic             pop,
    output vdeser_tag_t      head_tag,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    vdeser_tag_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
        next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign head_tag = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge CLK) begin
        if (do_push && !clr) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/rv32v_mem_deserializer.sv
// Vector load-response deserializer: tags requests, aligns/extends LSC words into per-lane data.
// Optional RV32V_DESER_FWD_EN: forward completing data and vload_done in the response cycle.
module rv32v_mem_deserializer
    import rv32i_types_pkg::*;
    import rv32v_types_pkg::*;
#(
    parameter int unsigned TAG_DEPTH = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        vstart,
    input  logic [NUM_LANES-1:0]        ven_lanes,
    input  logic [NUM_LANES-1:0]        vlane_mask,
    input  logic                        vreq_fire,
    input  logic [LANE_W-1:0]           vreq_lane,
    input  load_t                       vreq_type,
    input  logic [1:0]                  vreq_boff,
    output logic                        vdeser_ready,
    input  logic                        vrsp_valid,
    input  word_t                       vrsp_data,
    input  logic                        vflush,
    output word_t [NUM_LANES-1:0]       vlane_load_data,
    output logic [NUM_LANES-1:0]        vlane_load_valid,
    output logic                        vload_done,
    output logic                        vdeser_busy,
    output logic                        vdeser_err
);

    localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

    vdeser_state_t         state;
    logic [NUM_LANES-1:0]  expect_q;
    word_t [NUM_LANES-1:0] data_q;
    logic [NUM_LANES-1:0]  valid_q;
    logic                  done_q;
    logic                  err_q;

    vdeser_tag_t           push_tag;
    vdeser_tag_t           head;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;

    logic                  push_req;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  cap_en;
    logic [NUM_LANES-1:0]  cap_vec;
    word_t                 cap_data;
    logic [CNT_W-1:0]      count_next;
    logic                  complete;
    logic                  err_set;

    assign push_tag = '{lane: vreq_lane, ltype: vreq_type, boff: vreq_boff};

    rv32v_deser_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (vflush),
        .push     (push_ok),
        .push_tag (push_tag),
        .pop      (pop_ok),
        .head_tag (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Flush overrides any push or pop in the same cycle.
    assign push_req   = vreq_fire && (state == COLLECT) && !vflush;
    assign pop_ok     = vrsp_valid && !empty && !vflush;
    assign push_ok    = push_req && (!full || pop_ok);
    assign cap_data   = load_extend(head.ltype, head.boff, vrsp_data);
    assign cap_en     = pop_ok && (state == COLLECT) && expect_q[head.lane];
    assign cap_vec    = cap_en ? (NUM_LANES'(1) << head.lane) : '0;
    assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    assign complete   = (state == COLLECT) && !vflush &&
                        ((valid_q | cap_vec) == expect_q) && (count_next == '0);
    assign err_set    = (vrsp_valid && empty) || (push_req && full && !pop_ok);

    assign vdeser_ready     = !full;
    assign vdeser_busy      = (state != IDLE);
    assign vdeser_err       = err_q;
    assign vlane_load_valid = valid_q;

`ifdef RV32V_DESER_FWD_EN
    always_comb begin
        vlane_load_data = data_q;
        if (cap_en) vlane_load_data[head.lane] = cap_data;
    end
    assign vload_done = done_q | complete;
`else
    assign vlane_load_data = data_q;
    assign vload_done      = done_q;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            expect_q <= '0;
            data_q   <= '0;
            valid_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (err_set) err_q <= 1'b1;
            if (vflush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (vstart) begin
                            expect_q <= ven_lanes & vlane_mask;
                            data_q   <= '0;
                            valid_q  <= '0;
                            if ((ven_lanes & vlane_mask) == '0) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state <= COLLECT;
                            end
                        end
                    end
                    COLLECT: begin
                        if (cap_en) begin
                            data_q[head.lane]  <= cap_data;
                            valid_q[head.lane] <= 1'b1;
                        end
                        if (complete) begin
`ifdef RV32V_DESER_FWD_EN
                            state  <= IDLE;
`else
                            state  <= DONE;
                            done_q <= 1'b1;
`endif
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32v_mem_deserializer.sv
// Scoreboard bench for rv32v_mem_deserializer: tags queued on fire, expected lane data on response.
module tb_rv32v_mem_deserializer;

    import rv32i_types_pkg::*;
    import rv32v_types_pkg::*;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  vstart = 1'b0;
    logic [NUM_LANES-1:0]  ven_lanes = '0;
    logic [NUM_LANES-1:0]  vlane_mask = '0;
    logic                  vreq_fire = 1'b0;
    logic [LANE_W-1:0]     vreq_lane = '0;
    load_t                 vreq_type = LW;
    logic [1:0]            vreq_boff = '0;
    logic                  vdeser_ready;
    logic                  vrsp_valid = 1'b0;
    word_t                 vrsp_data = '0;
    logic                  vflush = 1'b0;
    word_t [NUM_LANES-1:0] lane_data;
    logic [NUM_LANES-1:0]  lane_valid;
    logic                  vload_done;
    logic                  vdeser_busy;
    logic                  vdeser_err;

    rv32v_mem_deserializer #(.TAG_DEPTH(2)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .vstart           (vstart),
        .ven_lanes        (ven_lanes),
        .vlane_mask       (vlane_mask),
        .vreq_fire        (vreq_fire),
        .vreq_lane        (vreq_lane),
        .vreq_type        (vreq_type),
        .vreq_boff        (vreq_boff),
        .vdeser_ready     (vdeser_ready),
        .vrsp_valid       (vrsp_valid),
        .vrsp_data        (vrsp_data),
        .vflush           (vflush),
        .vlane_load_data  (lane_data),
        .vlane_load_valid (lane_valid),
        .vload_done       (vload_done),
        .vdeser_busy      (vdeser_busy),
        .vdeser_err       (vdeser_err)
    );

    always #5 CLK = ~CLK;

    typedef struct { int lane; load_t t; logic [1:0] boff; } tag_s;
    typedef struct { int lane; word_t val; } exp_s;

    tag_s tag_q[$];
    exp_s exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    logic done_in_cycle = 1'b0;

    always @(negedge CLK) if (vload_done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic word_t model_ext(load_t t, logic [1:0] boff, word_t d);
        word_t sh;
        sh = d >> (8 * boff);
        case (t)
            LB:      model_ext = (sh[7]  ? 32'hFFFFFF00 : 32'h0) | (sh & 32'h000000FF);
            LBU:     model_ext = sh & 32'h000000FF;
            LH:      model_ext = (sh[15] ? 32'hFFFF0000 : 32'h0) | (sh & 32'h0000FFFF);
            LHU:     model_ext = sh & 32'h0000FFFF;
            default: model_ext = d;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [NUM_LANES-1:0] en, input logic [NUM_LANES-1:0] m);
        vstart = 1'b1;
        ven_lanes = en;
        vlane_mask = m;
        tick();
        vstart = 1'b0;
    endtask

    // One cycle of fire and/or response; the response pops the oldest tag, the fire queues a new one.
    task automatic drive(input logic f, input int lane, input load_t t, input logic [1:0] boff,
                         input logic rv, input word_t rd);
        tag_s tg;
        exp_s e;
        vreq_fire = f;
        vreq_lane = LANE_W'(lane);
        vreq_type = t;
        vreq_boff = boff;
        vrsp_valid = rv;
        vrsp_data = rd;
        if (rv && tag_q.size() > 0) begin
            tg = tag_q.pop_front();
            e.lane = tg.lane;
            e.val = model_ext(tg.t, tg.boff, rd);
            exp_q.push_back(e);
        end
        if (f) begin
            tg.lane = lane;
            tg.t = t;
            tg.boff = boff;
            tag_q.push_back(tg);
        end
        #3 done_in_cycle = vload_done;
        @(posedge CLK);
        #1;
        vreq_fire = 1'b0;
        vrsp_valid = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (lane_data[e.lane] !== e.val || lane_valid[e.lane] !== 1'b1) begin
                failures++;
                $display("FAIL scoreboard lane%0d: got data=%h valid=%b, want data=%h valid=1",
                         e.lane, lane_data[e.lane], lane_valid[e.lane], e.val);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({vdeser_ready, vload_done, vdeser_busy, vdeser_err} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags: got rdy/done/busy/err=%b, want 1000",
                     {vdeser_ready, vload_done, vdeser_busy, vdeser_err});
        end
        checks++;
        if (lane_valid !== '0 || lane_data !== '0) begin
            failures++;
            $display("FAIL reset_lanes: got valid=%b data=%h, want 0/0", lane_valid, lane_data);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_lw(input word_t d0, input word_t d1);
        int base;
        base = done_cnt;
        start(2'b11, 2'b11);
        checks++;
        if (vdeser_busy !== 1'b1 || lane_valid !== 2'b00) begin
            failures++;
            $display("FAIL lw_start: got busy=%b valid=%b, want 1/00", vdeser_busy, lane_valid);
        end
        drive(1'b1, 0, LW, 2'd0, 1'b0, '0);
        drive(1'b1, 1, LW, 2'd0, 1'b0, '0);
        drive(1'b0, 0, LW, 2'd0, 1'b1, d0);
        drive(1'b0, 0, LW, 2'd0, 1'b1, d1);
        checks++;
`ifdef RV32V_DESER_FWD_EN
        if (done_in_cycle !== 1'b1) begin
            failures++;
            $display("FAIL lw_done_timing: got done=%b in final response cycle, want 1", done_in_cycle);
        end
`else
        if (vload_done !== 1'b1) begin
            failures++;
            $display("FAIL lw_done_timing: got done=%b cycle after final response, want 1", vload_done);
        end
`endif
        checks++;
        if ({lane_data[1], lane_data[0]} !== {d1, d0} || lane_valid !== 2'b11) begin
            failures++;
            $display("FAIL lw_data: got %h_%h valid=%b, want %h_%h valid=11",
                     lane_data[1], lane_data[0], lane_valid, d1, d0);
        end
        tick();
        checks++;
        if (vload_done !== 1'b0 || vdeser_busy !== 1'b0 || done_cnt - base !== 1) begin
            failures++;
            $display("FAIL lw_end: got done=%b busy=%b pulses=%0d, want 0/0/1",
                     vload_done, vdeser_busy, done_cnt - base);
        end
    endtask

    task automatic test_extend();
        start(2'b11, 2'b11);
        drive(1'b1, 0, LB,  2'd0, 1'b0, '0);
        drive(1'b1, 1, LBU, 2'd3, 1'b0, '0);
        drive(1'b0, 0, LW,  2'd0, 1'b1, 32'h80F1_7F82);
        drive(1'b0, 0, LW,  2'd0, 1'b1, 32'h80F1_7F82);
        checks++;
        if (lane_data[0] !== 32'hFFFF_FF82 || lane_data[1] !== 32'h0000_0080) begin
            failures++;
            $display("FAIL ext_byte: got lb=%h lbu=%h, want ffffff82/00000080", lane_data[0], lane_data[1]);
        end
        tick();
        start(2'b11, 2'b11);
        checks++;
        if (lane_valid !== 2'b00 || lane_data !== '0) begin
            failures++;
            $display("FAIL ext_clear_on_start: got valid=%b data=%h, want 00/0", lane_valid, lane_data);
        end
        drive(1'b1, 0, LH,  2'd2, 1'b0, '0);
        drive(1'b1, 1, LHU, 2'd0, 1'b0, '0);
        drive(1'b0, 0, LW,  2'd0, 1'b1, 32'h80F1_7F82);
        drive(1'b0, 0, LW,  2'd0, 1'b1, 32'h80F1_7F82);
        checks++;
        if (lane_data[0] !== 32'hFFFF_80F1 || lane_data[1] !== 32'h0000_7F82) begin
            failures++;
            $display("FAIL ext_half: got lh=%h lhu=%h, want ffff80f1/00007f82", lane_data[0], lane_data[1]);
        end
        tick();
    endtask

    task automatic test_mask();
        int base;
        base = done_cnt;
        start(2'b11, 2'b10);
        drive(1'b1, 1, LW, 2'd0, 1'b0, '0);
        drive(1'b0, 0, LW, 2'd0, 1'b1, 32'hCAFE_F00D);
        tick();
        checks++;
        if (lane_data[0] !== 32'h0 || lane_valid !== 2'b10 || done_cnt - base !== 1) begin
            failures++;
            $display("FAIL mask_partial: got lane0=%h valid=%b pulses=%0d, want 0/10/1",
                     lane_data[0], lane_valid, done_cnt - base);
        end
        base = done_cnt;
        start(2'b11, 2'b00);
        checks++;
        if (vload_done !== 1'b1) begin
            failures++;
            $display("FAIL mask_empty_done: got done=%b cycle after start, want 1", vload_done);
        end
        tick();
        checks++;
        if (vload_done !== 1'b0 || vdeser_busy !== 1'b0 || done_cnt - base !== 1) begin
            failures++;
            $display("FAIL mask_empty_end: got done=%b busy=%b pulses=%0d, want 0/0/1",
                     vload_done, vdeser_busy, done_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = done_cnt;
        start(2'b11, 2'b11);
        drive(1'b1, 0, LW, 2'd0, 1'b0, '0);
        drive(1'b1, 1, LW, 2'd0, 1'b0, '0);
        checks++;
        if (vdeser_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: got ready=%b with two tags, want 0", vdeser_ready);
        end
        drive(1'b1, 0, LH, 2'd2, 1'b1, 32'h1111_2222);
        checks++;
        if (vdeser_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_push_pop: got ready=%b after fire+response, want 0", vdeser_ready);
        end
        drive(1'b0, 0, LW, 2'd0, 1'b1, 32'h3333_4444);
        checks++;
        if (vdeser_ready !== 1'b1 || done_cnt !== base) begin
            failures++;
            $display("FAIL bp_pending: got ready=%b pulses=%0d, want 1/0", vdeser_ready, done_cnt - base);
        end
        drive(1'b0, 0, LW, 2'd0, 1'b1, 32'h80F1_7F82);
        tick();
        checks++;
        if (lane_data[0] !== 32'hFFFF_80F1 || lane_data[1] !== 32'h3333_4444 || done_cnt - base !== 1) begin
            failures++;
            $display("FAIL bp_final: got %h_%h pulses=%0d, want 33334444_ffff80f1 pulses=1",
                     lane_data[1], lane_data[0], done_cnt - base);
        end
    endtask

    task automatic test_flush();
        int base;
        base = done_cnt;
        start(2'b11, 2'b11);
        drive(1'b1, 0, LW, 2'd0, 1'b0, '0);
        drive(1'b1, 1, LW, 2'd0, 1'b0, '0);
        drive(1'b0, 0, LW, 2'd0, 1'b1, 32'hA5A5_A5A5);
        vflush = 1'b1;
        tick();
        vflush = 1'b0;
        tag_q.delete();
        checks++;
        if (vdeser_busy !== 1'b0 || vdeser_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle: got busy=%b ready=%b, want 0/1", vdeser_busy, vdeser_ready);
        end
        tick();
        checks++;
        if (done_cnt !== base || vdeser_err !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_done: got pulses=%0d err=%b, want 0/0", done_cnt - base, vdeser_err);
        end
        drive(1'b0, 0, LW, 2'd0, 1'b1, 32'h0000_0001);
        tick();
        checks++;
        if (vdeser_err !== 1'b1) begin
            failures++;
            $display("FAIL flush_err: got err=%b after response with empty FIFO, want 1", vdeser_err);
        end
    endtask

    task automatic test_rst_mid();
        start(2'b11, 2'b11);
        drive(1'b1, 0, LW, 2'd0, 1'b0, '0);
        drive(1'b0, 0, LW, 2'd0, 1'b1, 32'h0000_0055);
        drive(1'b1, 1, LW, 2'd0, 1'b0, '0);
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({vdeser_ready, vload_done, vdeser_busy, vdeser_err} !== 4'b1000 ||
            lane_valid !== '0 || lane_data !== '0) begin
            failures++;
            $display("FAIL rst_async: got rdy/done/busy/err=%b valid=%b data=%h, want 1000/0/0",
                     {vdeser_ready, vload_done, vdeser_busy, vdeser_err}, lane_valid, lane_data);
        end
        tag_q.delete();
        exp_q.delete();
        tick();
        RST = 1'b0;
        tick();
        test_lw(32'h0BAD_F00D, 32'h600D_CAFE);
    endtask

    initial begin
        test_reset();
        test_lw(32'hDEAD_BEEF, 32'h1234_5678);
        test_extend();
        test_mask();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
